// File: rtl/mem_req_arbiter.sv
// Shares one memory request port between I-cache refills, D-cache refills and D-cache write-backs.
// Latency: a request pulse in cycle N issues m_start_rq in cycle N+2 at the earliest; responses route combinationally.
// Backpressure: no issue while m_rqfull is high; one transaction outstanding; requests wait in per-source hold registers.
// Optional feature: define MEM_ARB_RR_EN for round-robin between the two read sources (write-back stays highest).
module mem_req_arbiter #(
  parameter int TMO_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icr_start_rq,
  input  logic [31:0]  ic_rin_addr,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         m_start_rq,
  output logic         m_wr,
  output logic [31:0]  m_addr,
  output logic [15:0]  m_mask,
  output logic [127:0] m_wdata,
  input  logic         m_rqfull,
  input  logic         m_rdat_valid,
  input  logic [127:0] m_rdat_data,
  input  logic         m_finish_mrd,
  input  logic         m_finish_wresp,
  output logic         ic_rdat_m_valid,
  output logic         ic_finish_mrd,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic [127:0] rdat_m_data,
  output logic         dcw_finish_wresp,
  output logic         arb_busy,
  output logic [1:0]   arb_owner,
  output logic         req_overrun,
  output logic         arb_timeout
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT_RD = 2'd1, ST_WAIT_WR = 2'd2} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IR   = 2'd1;
  localparam logic [1:0] OWN_DR   = 2'd2;
  localparam logic [1:0] OWN_DW   = 2'd3;

  state_t             state_q, state_d;
  logic               pend_ir_q, pend_ir_d;
  logic               pend_dr_q, pend_dr_d;
  logic               pend_dw_q, pend_dw_d;
  logic [31:0]        hold_ir_addr_q, hold_ir_addr_d;
  logic [31:0]        hold_dr_addr_q, hold_dr_addr_d;
  logic [31:0]        hold_dw_addr_q, hold_dw_addr_d;
  logic [15:0]        hold_dw_mask_q, hold_dw_mask_d;
  logic [127:0]       hold_dw_data_q, hold_dw_data_d;
  logic               m_start_rq_q, m_start_rq_d;
  logic               m_wr_q, m_wr_d;
  logic [31:0]        m_addr_q, m_addr_d;
  logic [15:0]        m_mask_q, m_mask_d;
  logic [127:0]       m_wdata_q, m_wdata_d;
  logic [1:0]         owner_q, owner_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_inc;
  logic               gnt_ir, gnt_dr, gnt_dw;
`ifdef MEM_ARB_RR_EN
  logic               last_rd_q, last_rd_d;  // 0 = IR was the last read granted, 1 = DR
`endif

  // Winner selection: only from IDLE with memory ready; write-back always first.
  always_comb begin
    gnt_ir = 1'b0;
    gnt_dr = 1'b0;
    gnt_dw = 1'b0;
    if (state_q == ST_IDLE && !m_rqfull) begin
      if (pend_dw_q) begin
        gnt_dw = 1'b1;
`ifdef MEM_ARB_RR_EN
      end else if (pend_dr_q && pend_ir_q) begin
        gnt_dr = !last_rd_q;
        gnt_ir = last_rd_q;
`endif
      end else if (pend_dr_q) begin
        gnt_dr = 1'b1;
      end else if (pend_ir_q) begin
        gnt_ir = 1'b1;
      end
    end
  end

  // Saturating increment so the timeout counter never wraps.
  assign tmo_cnt_inc = (tmo_cnt_q == {TMO_W{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

  // Request capture: a new pulse beats a same-cycle grant; a pulse onto an ungranted pending slot is an overrun.
  always_comb begin
    pend_ir_d      = pend_ir_q;
    pend_dr_d      = pend_dr_q;
    pend_dw_d      = pend_dw_q;
    hold_ir_addr_d = hold_ir_addr_q;
    hold_dr_addr_d = hold_dr_addr_q;
    hold_dw_addr_d = hold_dw_addr_q;
    hold_dw_mask_d = hold_dw_mask_q;
    hold_dw_data_d = hold_dw_data_q;
    overrun_d      = overrun_q;
    if (gnt_ir) pend_ir_d = 1'b0;
    if (gnt_dr) pend_dr_d = 1'b0;
    if (gnt_dw) pend_dw_d = 1'b0;
    if (icr_start_rq) begin
      pend_ir_d      = 1'b1;
      hold_ir_addr_d = ic_rin_addr;
      if (pend_ir_q && !gnt_ir) overrun_d = 1'b1;
    end
    if (dcr_start_rq) begin
      pend_dr_d      = 1'b1;
      hold_dr_addr_d = dcr_rin_addr;
      if (pend_dr_q && !gnt_dr) overrun_d = 1'b1;
    end
    if (dcw_start_rq) begin
      pend_dw_d      = 1'b1;
      hold_dw_addr_d = dcw_in_addr;
      hold_dw_mask_d = dcw_in_mask;
      hold_dw_data_d = dcw_in_data;
      if (pend_dw_q && !gnt_dw) overrun_d = 1'b1;
    end
  end

  // Transaction FSM: issue from IDLE, wait for completion or timeout, then return to IDLE.
  always_comb begin
    state_d      = state_q;
    m_start_rq_d = 1'b0;
    m_wr_d       = m_wr_q;
    m_addr_d     = m_addr_q;
    m_mask_d     = m_mask_q;
    m_wdata_d    = m_wdata_q;
    owner_d      = owner_q;
    timeout_d    = timeout_q;
    tmo_cnt_d    = tmo_cnt_q;
`ifdef MEM_ARB_RR_EN
    last_rd_d    = last_rd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_dw) begin
          state_d      = ST_WAIT_WR;
          m_start_rq_d = 1'b1;
          m_wr_d       = 1'b1;
          m_addr_d     = hold_dw_addr_q;
          m_mask_d     = hold_dw_mask_q;
          m_wdata_d    = hold_dw_data_q;
          owner_d      = OWN_DW;
          tmo_cnt_d    = '0;
        end else if (gnt_dr || gnt_ir) begin
          state_d      = ST_WAIT_RD;
          m_start_rq_d = 1'b1;
          m_wr_d       = 1'b0;
          m_addr_d     = gnt_dr ? hold_dr_addr_q : hold_ir_addr_q;
          m_mask_d     = 16'hffff;
          m_wdata_d    = '0;
          owner_d      = gnt_dr ? OWN_DR : OWN_IR;
          tmo_cnt_d    = '0;
`ifdef MEM_ARB_RR_EN
          last_rd_d    = gnt_dr;
`endif
        end
      end
      ST_WAIT_RD, ST_WAIT_WR: begin
        if ((state_q == ST_WAIT_RD && m_finish_mrd) ||
            (state_q == ST_WAIT_WR && m_finish_wresp)) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
          if (tmo_cnt_inc == {TMO_W{1'b1}}) begin
            state_d   = ST_IDLE;
            owner_d   = OWN_NONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pend_ir_q      <= 1'b0;
      pend_dr_q      <= 1'b0;
      pend_dw_q      <= 1'b0;
      hold_ir_addr_q <= '0;
      hold_dr_addr_q <= '0;
      hold_dw_addr_q <= '0;
      hold_dw_mask_q <= '0;
      hold_dw_data_q <= '0;
      m_start_rq_q   <= 1'b0;
      m_wr_q         <= 1'b0;
      m_addr_q       <= '0;
      m_mask_q       <= '0;
      m_wdata_q      <= '0;
      owner_q        <= OWN_NONE;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
      tmo_cnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_rd_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pend_ir_q      <= pend_ir_d;
      pend_dr_q      <= pend_dr_d;
      pend_dw_q      <= pend_dw_d;
      hold_ir_addr_q <= hold_ir_addr_d;
      hold_dr_addr_q <= hold_dr_addr_d;
      hold_dw_addr_q <= hold_dw_addr_d;
      hold_dw_mask_q <= hold_dw_mask_d;
      hold_dw_data_q <= hold_dw_data_d;
      m_start_rq_q   <= m_start_rq_d;
      m_wr_q         <= m_wr_d;
      m_addr_q       <= m_addr_d;
      m_mask_q       <= m_mask_d;
      m_wdata_q      <= m_wdata_d;
      owner_q        <= owner_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
      tmo_cnt_q      <= tmo_cnt_d;
`ifdef MEM_ARB_RR_EN
      last_rd_q      <= last_rd_d;
`endif
    end
  end

  assign m_start_rq       = m_start_rq_q;
  assign m_wr             = m_wr_q;
  assign m_addr           = m_addr_q;
  assign m_mask           = m_mask_q;
  assign m_wdata          = m_wdata_q;
  assign arb_owner        = owner_q;
  assign arb_busy         = (state_q != ST_IDLE);
  assign req_overrun      = overrun_q;
  assign arb_timeout      = timeout_q;
  // Owner-gated response routing; owner is NONE whenever nothing is outstanding.
  assign ic_rdat_m_valid  = m_rdat_valid   && (owner_q == OWN_IR);
  assign ic_finish_mrd    = m_finish_mrd   && (owner_q == OWN_IR);
  assign rdat_m_valid     = m_rdat_valid   && (owner_q == OWN_DR);
  assign finish_mrd       = m_finish_mrd   && (owner_q == OWN_DR);
  assign dcw_finish_wresp = m_finish_wresp && (owner_q == OWN_DW);
  assign rdat_m_data      = m_rdat_data;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations plus a randomized phase.
// A transaction-level reference model predicts every output each cycle; a compare process checks it on negedges.
module tb_mem_req_arbiter;
  localparam int TMO_W = 4;
  localparam int LIM   = (1 << TMO_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic icr_start_rq = 0, dcr_start_rq = 0, dcw_start_rq = 0;
  logic [31:0] ic_rin_addr = 0, dcr_rin_addr = 0, dcw_in_addr = 0;
  logic [15:0] dcw_in_mask = 0;
  logic [127:0] dcw_in_data = 0, m_rdat_data = 0;
  logic m_rqfull = 0, m_rdat_valid = 0, m_finish_mrd = 0, m_finish_wresp = 0;
  logic m_start_rq, m_wr, ic_rdat_m_valid, ic_finish_mrd, rdat_m_valid, finish_mrd;
  logic dcw_finish_wresp, arb_busy, req_overrun, arb_timeout;
  logic [31:0] m_addr;
  logic [15:0] m_mask;
  logic [127:0] m_wdata, rdat_m_data;
  logic [1:0] arb_owner;

  int errs = 0, checks = 0;

  mem_req_arbiter #(.TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst),
    .icr_start_rq(icr_start_rq), .ic_rin_addr(ic_rin_addr),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
    .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr),
    .dcw_in_mask(dcw_in_mask), .dcw_in_data(dcw_in_data),
    .m_start_rq(m_start_rq), .m_wr(m_wr), .m_addr(m_addr), .m_mask(m_mask), .m_wdata(m_wdata),
    .m_rqfull(m_rqfull), .m_rdat_valid(m_rdat_valid), .m_rdat_data(m_rdat_data),
    .m_finish_mrd(m_finish_mrd), .m_finish_wresp(m_finish_wresp),
    .ic_rdat_m_valid(ic_rdat_m_valid), .ic_finish_mrd(ic_finish_mrd),
    .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd), .rdat_m_data(rdat_m_data),
    .dcw_finish_wresp(dcw_finish_wresp), .arb_busy(arb_busy), .arb_owner(arb_owner),
    .req_overrun(req_overrun), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (1=IR, 2=DR, 3=DW) ----------------
  int          own = 0, wcnt = 0, last_rd = 1;
  bit          pend[4];
  logic [31:0] haddr[4];
  logic [15:0] hmask = 0;
  logic [127:0] hdata = 0;
  logic        e_start = 0, e_wr = 0, e_ovr = 0, e_tmo = 0;
  logic [31:0] e_addr = 0;
  logic [15:0] e_mask = 0;
  logic [127:0] e_wdata = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin pend[i] = 0; haddr[i] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        own = 0; wcnt = 0; last_rd = 1; hmask = 0; hdata = 0;
        for (int i = 0; i < 4; i++) begin pend[i] = 0; haddr[i] = 0; end
        e_start = 0; e_wr = 0; e_ovr = 0; e_tmo = 0; e_addr = 0; e_mask = 0; e_wdata = 0;
      end else begin
        int g;
        bit p[4];
        logic [31:0] na[4];
        g = 0;
        e_start = 0;
        p[1] = icr_start_rq; p[2] = dcr_start_rq; p[3] = dcw_start_rq;
        na[1] = ic_rin_addr; na[2] = dcr_rin_addr; na[3] = dcw_in_addr;
        if (own != 0) begin
          if ((own != 3 && m_finish_mrd) || (own == 3 && m_finish_wresp)) own = 0;
          else begin
            if (wcnt < LIM) wcnt++;
            if (wcnt == LIM) begin own = 0; e_tmo = 1; end
          end
        end else if (!m_rqfull) begin
          if (pend[3]) g = 3;
`ifdef MEM_ARB_RR_EN
          else if (pend[2] && pend[1]) g = (last_rd == 1) ? 2 : 1;
`endif
          else if (pend[2]) g = 2;
          else if (pend[1]) g = 1;
          if (g != 0) begin
            e_start = 1; e_wr = (g == 3); e_addr = haddr[g];
            e_mask = (g == 3) ? hmask : 16'hffff;
            e_wdata = (g == 3) ? hdata : '0;
            own = g; wcnt = 0;
            if (g != 3) last_rd = g;
          end
        end
        for (int s = 1; s < 4; s++) begin
          if (p[s]) begin
            if (pend[s] && g != s) e_ovr = 1;
            pend[s] = 1; haddr[s] = na[s];
            if (s == 3) begin hmask = dcw_in_mask; hdata = dcw_in_data; end
          end else if (g == s) pend[s] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("m_start_rq", m_start_rq, e_start);
    chk("m_wr", m_wr, e_wr);
    chk("m_addr", m_addr, e_addr);
    chk("m_mask", m_mask, e_mask);
    chk("m_wdata", m_wdata, e_wdata);
    chk("arb_owner", arb_owner, own[1:0]);
    chk("arb_busy", arb_busy, own != 0);
    chk("req_overrun", req_overrun, e_ovr);
    chk("arb_timeout", arb_timeout, e_tmo);
    chk("ic_rdat_m_valid", ic_rdat_m_valid, m_rdat_valid && own == 1);
    chk("ic_finish_mrd", ic_finish_mrd, m_finish_mrd && own == 1);
    chk("rdat_m_valid", rdat_m_valid, m_rdat_valid && own == 2);
    chk("finish_mrd", finish_mrd, m_finish_mrd && own == 2);
    chk("dcw_finish_wresp", dcw_finish_wresp, m_finish_wresp && own == 3);
    chk("rdat_m_data", rdat_m_data, m_rdat_data);
  end

  // ---------------- directed helpers (all start and end just after a posedge) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0; step();
  endtask

  task automatic pulse(input bit ir, input bit dr, input bit dw, input logic [31:0] a);
    icr_start_rq = ir; dcr_start_rq = dr; dcw_start_rq = dw;
    ic_rin_addr = a; dcr_rin_addr = a + 32'h100; dcw_in_addr = a + 32'h200;
    dcw_in_mask = 16'h0f0f; dcw_in_data = {4{a}};
    step();
    icr_start_rq = 0; dcr_start_rq = 0; dcw_start_rq = 0;
  endtask

  // Counts clock edges from the last sampled stimulus until m_start_rq is seen; ends at that negedge.
  task automatic wait_start(input string nm, output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (m_start_rq) return;
      if (n >= 60) begin chk({nm, "_wait_expired"}, 0, 1); return; end
      step(); n++;
    end
  endtask

  task automatic fin_rd();
    step(); m_finish_mrd = 1; step(); m_finish_mrd = 0;
  endtask

  int n, icn, dcn;

  initial begin
    #1; step(); step(); rst = 0; step();
    // reset state
    chk("rst_start", m_start_rq, 0); chk("rst_busy", arb_busy, 0);
    chk("rst_owner", arb_owner, 0); chk("rst_addr", m_addr, 0);

    // 1: single IR read, 4 beats
    pulse(1, 0, 0, 32'h1000);
    wait_start("t1", n);
    chk("t1_latency", n, 2); chk("t1_addr", m_addr, 32'h1000); chk("t1_wr", m_wr, 0);
    chk("t1_mask", m_mask, 16'hffff);
    step(); icn = 0; dcn = 0;
    for (int i = 0; i < 4; i++) begin
      m_rdat_valid = 1; m_rdat_data = 128'hab00 + i;
      @(negedge clk); if (ic_rdat_m_valid) icn++; if (rdat_m_valid) dcn++;
      step();
    end
    m_rdat_valid = 0; m_finish_mrd = 1;
    @(negedge clk); chk("t1_ic_finish", ic_finish_mrd, 1); chk("t1_dc_finish", finish_mrd, 0);
    step(); m_finish_mrd = 0;
    @(negedge clk); chk("t1_busy_drop", arb_busy, 0);
    chk("t1_ic_beats", icn, 4); chk("t1_dc_beats", dcn, 0);
    step();

    // 2: all three at once -> DW, DR, IR
    pulse(1, 1, 1, 32'h2000);
    wait_start("t2a", n);
    chk("t2_dw_wr", m_wr, 1); chk("t2_dw_owner", arb_owner, 3);
    chk("t2_dw_addr", m_addr, 32'h2200); chk("t2_dw_mask", m_mask, 16'h0f0f);
    step(); m_finish_wresp = 1;
    @(negedge clk); chk("t2_wresp", dcw_finish_wresp, 1);
    step(); m_finish_wresp = 0;
    wait_start("t2b", n);
    chk("t2_dr_gap", n, 2); chk("t2_dr_owner", arb_owner, 2); chk("t2_dr_addr", m_addr, 32'h2100);
    fin_rd();
    wait_start("t2c", n);
    chk("t2_ir_gap", n, 2); chk("t2_ir_owner", arb_owner, 1); chk("t2_ir_addr", m_addr, 32'h2000);
    fin_rd();
    // IR was granted last: with DR and IR tied, DR wins under either policy
    pulse(1, 1, 0, 32'h2800);
    wait_start("t2d", n);
    chk("t2_tie_owner", arb_owner, 2);
    fin_rd();
    wait_start("t2e", n);
    chk("t2_tie_next", arb_owner, 1);
    fin_rd(); step(); step();

    // 3: m_rqfull holds off a pending DR
    m_rqfull = 1;
    pulse(0, 1, 0, 32'h3000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("t3_no_issue", m_start_rq, 0); step();
    end
    m_rqfull = 0; step();
    wait_start("t3", n);
    chk("t3_latency", n, 1); chk("t3_addr", m_addr, 32'h3100);
    fin_rd(); step();

    // 4a: overrun while pending and not granted
    m_rqfull = 1;
    pulse(0, 1, 0, 32'h4000);
    pulse(0, 1, 0, 32'h4400);
    @(negedge clk); chk("t4_overrun", req_overrun, 1);
    step(); m_rqfull = 0; step();
    wait_start("t4a", n);
    chk("t4_later_addr", m_addr, 32'h4500);
    fin_rd();
    // 4b: pulse in the grant cycle -> two reads, no overrun
    do_reset();
    pulse(0, 1, 0, 32'h5000);
    pulse(0, 1, 0, 32'h5400);
    wait_start("t4b", n);
    chk("t4b_first", m_addr, 32'h5100);
    fin_rd();
    wait_start("t4c", n);
    chk("t4b_second", m_addr, 32'h5500); chk("t4b_no_overrun", req_overrun, 0);
    fin_rd(); step();

    // 5: timeout after 15 WAIT cycles; a DR queued meanwhile issues next
    pulse(1, 0, 0, 32'h6000);
    wait_start("t5", n);
    n = 0;
    while (arb_busy && n < 40) begin
      n++;
      dcr_rin_addr = 32'h6100; dcr_start_rq = (n == 3);
      @(negedge clk);
    end
    dcr_start_rq = 0;
    chk("t5_wait_cycles", n, 15); chk("t5_timeout", arb_timeout, 1);
    step();
    wait_start("t5b", n);
    chk("t5_next_owner", arb_owner, 2); chk("t5_next_addr", m_addr, 32'h6100);
    fin_rd(); step();

    // 6: reset during WAIT_WR
    do_reset();
    pulse(0, 0, 1, 32'h7000);
    wait_start("t6", n);
    step(); rst = 1; #1;
    chk("t6_busy", arb_busy, 0); chk("t6_owner", arb_owner, 0);
    chk("t6_addr", m_addr, 0); chk("t6_wr", m_wr, 0); chk("t6_start", m_start_rq, 0);
    step(); step(); rst = 0; step();
    m_finish_wresp = 1; #1;
    chk("t6_no_wresp", dcw_finish_wresp, 0);
    step(); m_finish_wresp = 0; step();

    // randomized phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      icr_start_rq = ($urandom_range(7) == 0);
      dcr_start_rq = ($urandom_range(7) == 0);
      dcw_start_rq = ($urandom_range(9) == 0);
      ic_rin_addr = $urandom; dcr_rin_addr = $urandom; dcw_in_addr = $urandom;
      dcw_in_mask = 16'($urandom);
      dcw_in_data = {$urandom, $urandom, $urandom, $urandom};
      m_rqfull = ($urandom_range(3) == 0);
      m_rdat_valid = ($urandom_range(2) == 0);
      m_rdat_data = {$urandom, $urandom, $urandom, $urandom};
      m_finish_mrd = ($urandom_range(9) == 0);
      m_finish_wresp = ($urandom_range(9) == 0);
      step();
    end
    icr_start_rq = 0; dcr_start_rq = 0; dcw_start_rq = 0; m_rqfull = 0;
    m_rdat_valid = 0; m_finish_mrd = 0; m_finish_wresp = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
